down_count_timer: RTL and testbench
===================================

Name: down_count_timer

Overview:
- Loadable down-counter/timer. It is the counting-down counterpart to the team's up-counter.
- Software or an upstream FSM loads a terminal value, and the block decrements toward zero on each enabled tick.
- It emits a one-cycle terminal-count pulse when the count expires.
- It supports one-shot and auto-reload (periodic) modes and serves as a timeout and period generator beside the up-counter.

Parameters:
WIDTH, 5, counter and load-value width in bits (unsigned)
PRESCALE, 4, enabled ticks per decrement when DOWN_PRESCALE_EN is defined (must be >= 1)

Ports:
clk  input  1  clock, all state changes on rising edge
clr  input  1  reset; synchronous, active-high; clears all state
load  input  1  capture load_val into count and reload register, start run
load_val  input  WIDTH  value to count down from (0 = do not start)
en  input  1  tick enable; one decrement opportunity per cycle
auto_rl  input  1  1 = auto-reload at expiry, 0 = one-shot; sampled at expiry cycle
q  output  WIDTH  current count (registered)
tc  output  1  terminal-count pulse, high exactly one cycle per expiry (registered)
busy  output  1  high while in RUN state (registered)

Behaviour:
- Interface: one clock, clk. Reset clr is synchronous and active-high.
- Reset:
  - clr=1 at a rising edge forces the following: q=0, reload register=0, tc=0, busy=0, state=IDLE, prescaler=0.
  - clr overrides load and en in the same cycle. Asserting clr mid-run aborts the run with no tc pulse.
- States: IDLE (busy=0) and RUN (busy=1).
- Priority per cycle: clr > load > en tick > hold.
- Load (any state):
  - q<=load_val, reload<=load_val, tc<=0.
  - The next state is RUN if load_val!=0. Otherwise it is IDLE with q=0.
  - The prescaler clears on load.
  - q and busy reflect the load on the cycle after it is sampled (1-cycle latency).
- RUN, en=1, q>1: q<=q-1, tc<=0.
- RUN, en=1, q==1 (expiry):
  - tc<=1 for one cycle.
  - If auto_rl=1: q<=reload and the block stays in RUN.
  - If auto_rl=0: q<=0 and the state becomes IDLE.
  - Period in auto-reload mode is exactly reload enabled ticks. q never reads 0 in auto-reload mode.
- RUN, en=0: q holds and tc<=0.
- IDLE: q holds, tc<=0, and en is ignored. There is no underflow or wrap: q=0 with en=1 stays 0.
- Load coincident with expiry (q==1, en=1, load=1): load wins and no tc is issued.
- tc is never high for two consecutive cycles unless reload=1 in auto-reload mode with en held high. In that case tc is high on every cycle.
- Arithmetic:
  - Unsigned WIDTH-bit decrement.
  - The maximum period is 2^WIDTH-1 ticks (31 at the default).

Optional Feature:
DOWN_PRESCALE_EN
- Defined:
  - An internal prescaler counts en-high cycles while in RUN.
  - A decrement or expiry opportunity occurs only on every PRESCALE-th en-high cycle, i.e. when the prescaler reaches PRESCALE-1. The prescaler then wraps to 0.
  - Prescaler behaviour on other events:
    - en=0 holds the prescaler.
    - load and clr clear it.
    - Entering IDLE clears it.
  - The effective period is reload*PRESCALE en-cycles.
- Undefined: no prescaler logic exists, and every en-high cycle in RUN is a decrement opportunity. PRESCALE is ignored.

Test Plan:
- Reset: clr=1 for 2 cycles during an active run (q=7) -> q=0, tc=0, busy=0 on the cycle after the first clr edge. en=1 after release leaves q=0.
- One-shot:
  - Stimulus: load_val=5, auto_rl=0, en=1 continuously.
  - q sequence: 5,4,3,2,1,0.
  - tc is high on the single cycle when q first reads 0, and busy falls on that same cycle.
  - q then stays 0.
- Auto-reload:
  - Stimulus: load_val=3, auto_rl=1, en=1 for 12 cycles.
  - q sequence: 3,2,1,3,2,1,3...
  - tc is high every 3rd cycle, coincident with q returning to 3, for 4 pulses total.
  - busy stays 1.
- Gated enable: load_val=4, en toggling 1,0,1,0... -> q decrements only after en-high cycles; tc asserts after the 4th en-high cycle. A zero-load case (load_val=0) -> busy stays 0, q=0, and no tc ever asserts.
- Collisions:
  - load_val=9 loaded on the cycle where q==1 and en=1 -> next q=9, tc=0.
  - clr and load high together -> q=0, busy=0.
  - load_val=31 (max) one-shot -> tc after exactly 31 enabled ticks.
- DOWN_PRESCALE_EN defined, PRESCALE=4: load_val=2, en=1 continuously -> q goes 2 to 1 after 4 cycles; tc pulses after 8 cycles. With the macro undefined, the same stimulus gives tc after 2 cycles.

Source files
------------

// File: rtl/down_count_timer.sv
// down_count_timer: loadable down-counter / timeout and period generator.
// Loads a terminal value, decrements once per enabled tick while running, and
// emits a one-cycle terminal-count pulse (tc) when the count expires.
// Supports one-shot and auto-reload modes.
// Optional feature macro: DOWN_PRESCALE_EN. When it is defined, a prescaler
// makes only every PRESCALE-th en-high cycle a decrement opportunity.
module down_count_timer #(
    parameter int WIDTH    = 5,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             auto_rl,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] q_r, q_s;
    logic [WIDTH-1:0] reload_r, reload_s;
    logic             tc_r, tc_s;
    logic             busy_r;
    logic             tick_s;

`ifdef DOWN_PRESCALE_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_r, presc_s;

    // A tick happens only on the en-high cycle where the prescaler is at its last value.
    always_comb begin
        tick_s = (state_r == RUN) && en && (presc_r == PRESC_MAX);
    end

    // Prescaler next value: clear on load or on leaving RUN, count en-high cycles in RUN.
    always_comb begin
        presc_s = presc_r;
        if (load) begin
            presc_s = {PW{1'b0}};
        end else if ((state_r == RUN) && en) begin
            if (presc_r == PRESC_MAX) begin
                presc_s = {PW{1'b0}};
            end else begin
                presc_s = presc_r + PW'(1);
            end
        end else begin
            presc_s = presc_r;
        end
        if (state_s == IDLE) begin
            presc_s = {PW{1'b0}};
        end else begin
            presc_s = presc_s;
        end
    end

    // Prescaler register, cleared by clr.
    always_ff @(posedge clk) begin
        if (clr) begin
            presc_r <= {PW{1'b0}};
        end else begin
            presc_r <= presc_s;
        end
    end
`else
    // Without the prescaler every en-high cycle in RUN is a decrement opportunity.
    always_comb begin
        tick_s = (state_r == RUN) && en;
    end
`endif

    // Next-state, next-count and terminal-count logic; load beats a tick.
    always_comb begin
        state_s  = state_r;
        q_s      = q_r;
        reload_s = reload_r;
        tc_s     = 1'b0;
        if (load) begin
            q_s      = load_val;
            reload_s = load_val;
            if (load_val != {WIDTH{1'b0}}) begin
                state_s = RUN;
            end else begin
                state_s = IDLE;
            end
        end else begin
            case (state_r)
                RUN: begin
                    if (tick_s) begin
                        if (q_r > WIDTH'(1)) begin
                            q_s = q_r - WIDTH'(1);
                        end else begin
                            // Expiry: q==1 (q==0 cannot occur in RUN but is treated alike).
                            tc_s = 1'b1;
                            if (auto_rl) begin
                                q_s = reload_r;
                            end else begin
                                q_s     = {WIDTH{1'b0}};
                                state_s = IDLE;
                            end
                        end
                    end else begin
                        q_s = q_r;
                    end
                end
                IDLE: begin
                    q_s = q_r;
                end
                default: begin
                    q_s     = {WIDTH{1'b0}};
                    state_s = IDLE;
                end
            endcase
        end
    end

    // State and output registers; clr clears everything and aborts a run silently.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r  <= IDLE;
            q_r      <= {WIDTH{1'b0}};
            reload_r <= {WIDTH{1'b0}};
            tc_r     <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            q_r      <= q_s;
            reload_r <= reload_s;
            tc_r     <= tc_s;
            busy_r   <= (state_s == RUN);
        end
    end

    assign q    = q_r;
    assign tc   = tc_r;
    assign busy = busy_r;

endmodule

// File: tb/tb_down_count_timer.sv
// Directed self-checking bench for down_count_timer.
// Instance dut has PRESCALE=1, so it behaves as an unprescaled timer in
// either build. Instance dut4 has PRESCALE=4 and exercises the prescaler
// when DOWN_PRESCALE_EN is defined.
module tb_down_count_timer;

    localparam int W = 5;

    logic         clk;
    logic         clr;
    logic         load;
    logic [W-1:0] load_val;
    logic         en;
    logic         auto_rl;
    logic [W-1:0] q, q4;
    logic         tc, tc4;
    logic         busy, busy4;

    int n_assert;
    int n_fail;
    int tc_seen;
    int exp_q;
    int exp_tc;

    down_count_timer #(.WIDTH(W), .PRESCALE(1)) dut (
        .clk(clk), .clr(clr), .load(load), .load_val(load_val), .en(en),
        .auto_rl(auto_rl), .q(q), .tc(tc), .busy(busy)
    );

    down_count_timer #(.WIDTH(W), .PRESCALE(4)) dut4 (
        .clk(clk), .clr(clr), .load(load), .load_val(load_val), .en(en),
        .auto_rl(auto_rl), .q(q4), .tc(tc4), .busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        clr = 1'b1; load = 1'b0; load_val = 5'd0; en = 1'b0; auto_rl = 1'b0;

        // Reset state
        step();
        check("rst_q", int'(q), 0);
        check("rst_tc", int'(tc), 0);
        check("rst_busy", int'(busy), 0);
        clr = 1'b0;

        // clr during an active run at q=7
        load = 1'b1; load_val = 5'd7; step();
        load = 1'b0;
        check("run_q7", int'(q), 7);
        check("run_busy", int'(busy), 1);
        clr = 1'b1; en = 1'b1; step();
        check("clr_q", int'(q), 0);
        check("clr_tc", int'(tc), 0);
        check("clr_busy", int'(busy), 0);
        step();
        clr = 1'b0; step();
        check("postclr_q", int'(q), 0);
        check("postclr_busy", int'(busy), 0);

        // One-shot, load 5, en continuously
        load = 1'b1; load_val = 5'd5; auto_rl = 1'b0; step();
        load = 1'b0;
        check("os_q5", int'(q), 5);
        for (int i = 4; i >= 1; i--) begin
            step();
            check("os_q", int'(q), i);
            check("os_tc_lo", int'(tc), 0);
            check("os_busy", int'(busy), 1);
        end
        step();
        check("os_q0", int'(q), 0);
        check("os_tc", int'(tc), 1);
        check("os_busy_fall", int'(busy), 0);
        step();
        check("os_hold_q", int'(q), 0);
        check("os_tc_once", int'(tc), 0);

        // Auto-reload, load 3, 12 enabled cycles
        load = 1'b1; load_val = 5'd3; auto_rl = 1'b1; step();
        load = 1'b0;
        check("ar_q3", int'(q), 3);
        tc_seen = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            exp_q  = (k % 3 == 1) ? 2 : (k % 3 == 2) ? 1 : 3;
            exp_tc = (k % 3 == 0) ? 1 : 0;
            check("ar_q", int'(q), exp_q);
            check("ar_tc", int'(tc), exp_tc);
            check("ar_busy", int'(busy), 1);
            if (tc) tc_seen++;
        end
        check("ar_pulses", tc_seen, 4);

        // Gated enable, load 4, en 1,0,1,0...
        en = 1'b0; auto_rl = 1'b0;
        load = 1'b1; load_val = 5'd4; step();
        load = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            en = 1'b1; step();
            check("ge_q_hi", int'(q), 4 - i);
            check("ge_tc_hi", int'(tc), (i == 4) ? 1 : 0);
            en = 1'b0; step();
            check("ge_q_lo", int'(q), 4 - i);
            check("ge_tc_lo", int'(tc), 0);
        end

        // Zero load never starts
        load = 1'b1; load_val = 5'd0; step();
        load = 1'b0; en = 1'b1;
        check("z_busy", int'(busy), 0);
        check("z_q", int'(q), 0);
        tc_seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (tc || busy || (q != 5'd0)) tc_seen++;
        end
        check("z_quiet", tc_seen, 0);

        // Load coincident with expiry
        load = 1'b1; load_val = 5'd2; step();
        load = 1'b0; step();
        check("col_q1", int'(q), 1);
        load = 1'b1; load_val = 5'd9; step();
        load = 1'b0;
        check("col_q9", int'(q), 9);
        check("col_tc", int'(tc), 0);
        check("col_busy", int'(busy), 1);

        // clr and load together
        clr = 1'b1; load = 1'b1; load_val = 5'd5; step();
        clr = 1'b0; load = 1'b0;
        check("clrld_q", int'(q), 0);
        check("clrld_busy", int'(busy), 0);

        // Max value one-shot: tc after exactly 31 ticks
        load = 1'b1; load_val = 5'd31; step();
        load = 1'b0;
        tc_seen = 0;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (tc) tc_seen++;
        end
        check("max_no_early_tc", tc_seen, 0);
        check("max_q1", int'(q), 1);
        step();
        check("max_tc", int'(tc), 1);
        check("max_q0", int'(q), 0);

        // Prescaler: load 2, en continuously
        load = 1'b1; load_val = 5'd2; step();
        load = 1'b0;
        check("ps_load_q", int'(q4), 2);
        step();
        check("ps_dut_q1", int'(q), 1);
        step();
        check("ps_dut_tc", int'(tc), 1);
`ifdef DOWN_PRESCALE_EN
        check("ps4_q_2c", int'(q4), 2);
        step(); step();
        check("ps4_q_4c", int'(q4), 1);
        check("ps4_tc_4c", int'(tc4), 0);
        step(); step(); step();
        check("ps4_tc_7c", int'(tc4), 0);
        step();
        check("ps4_tc_8c", int'(tc4), 1);
        check("ps4_q_8c", int'(q4), 0);
        check("ps4_busy_8c", int'(busy4), 0);
`else
        check("ps4_tc_2c", int'(tc4), 1);
        check("ps4_q_2c", int'(q4), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
